opp_rx_parser: RTL and testbench

- Sits directly upstream of the game logic.
- Consumes the 2-bit ethernet receive payload stream (preamble and FCS already stripped) and assembles fixed-layout opponent state frames.
- Validates each frame and presents the last good opponent x/y/direction/game status, with a one-cycle receive_axiov strobe per accepted frame.
- Also tracks link liveness and frame-error statistics.

---
 rtl/opp_rx_parser.sv | 114 +++++++++++
 tb/tb_opp_rx_parser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/opp_rx_parser.sv
// rtl/opp_rx_parser.sv - opponent state frame parser on the 2-bit receive payload stream
module opp_rx_parser #(
    parameter logic [7:0] MAGIC          = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 5_000_000,
    parameter int         MAX_DIR        = 359
) (
    input  logic        clk,
    input  logic        btnc,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic [10:0] r_opp_x,
    output logic [10:0] r_opp_y,
    output logic [8:0]  r_opp_dir,
    output logic [2:0]  r_opp_game,
    output logic        receive_axiov,
    output logic        link_up,
    output logic [7:0]  bad_frames
);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [8:0]      DIR_MAX  = 9'(MAX_DIR);
    localparam logic [4:0]      FRAME_DB = 5'd28;

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t        state, state_nx;
    logic [4:0]    count;
    logic [55:0]   sr;
    logic [55:0]   sr_in;
    logic [TW-1:0] tcnt;
    logic [7:0]    xsum;
    logic          overrun, frame_end, good;

    // Frame layout, oldest dibit at the top: magic | x | y | dir | game | pad | checksum
    logic [10:0] f_x, f_y;
    logic [8:0]  f_dir;
    logic [2:0]  f_game;

    assign sr_in  = {sr[53:0], axiid};
    assign f_x    = sr[47:37];
    assign f_y    = sr[36:26];
    assign f_dir  = sr[25:17];
    assign f_game = sr[16:14];
    assign xsum   = sr[55:48] ^ sr[47:40] ^ sr[39:32] ^ sr[31:24]
                  ^ sr[23:16] ^ sr[15:8]  ^ sr[7:0];

    always_comb begin
        state_nx  = state;
        overrun   = 1'b0;
        frame_end = 1'b0;
        good      = 1'b0;
        case (state)
            DISCARD: if (!axiiv) state_nx = IDLE;
            IDLE:    if (axiiv)  state_nx = RECV;
            RECV: begin
                if (axiiv) begin
                    if (count == FRAME_DB) begin
                        overrun  = 1'b1;
                        state_nx = DISCARD;
                    end
                end else begin
                    frame_end = 1'b1;
                    state_nx  = IDLE;
                    good = (count == FRAME_DB) && (sr[55:48] == MAGIC) && (xsum == 8'h00)
                        && (f_dir <= DIR_MAX) && (f_game <= 3'd2);
                end
            end
            default: state_nx = DISCARD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (btnc) begin
            state         <= DISCARD;
            count         <= 5'd0;
            sr            <= 56'd0;
            tcnt          <= '0;
            r_opp_x       <= 11'd300;
            r_opp_y       <= 11'd100;
            r_opp_dir     <= 9'd90;
            r_opp_game    <= 3'd0;
            receive_axiov <= 1'b0;
            link_up       <= 1'b0;
            bad_frames    <= 8'd0;
        end else begin
            state         <= state_nx;
            receive_axiov <= good;
            if (state == IDLE && axiiv) begin
                count <= 5'd1;
                sr    <= sr_in;
            end else if (state == RECV && axiiv && !overrun) begin
                count <= count + 5'd1;
                sr    <= sr_in;
            end
            if ((overrun || (frame_end && !good)) && bad_frames != 8'hFF)
                bad_frames <= bad_frames + 8'd1;
            if (good) begin
                r_opp_x    <= f_x;
                r_opp_y    <= f_y;
                r_opp_dir  <= f_dir;
                r_opp_game <= f_game;
            end
            // Acceptance takes priority over the counter reaching its limit
            if (good) begin
                tcnt    <= '0;
                link_up <= 1'b1;
            end else if (tcnt < TMAX) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == TMAX - 1'b1)
                    link_up <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_opp_rx_parser.sv
// tb/tb_opp_rx_parser.sv - randomized frame bench with a field-level reference model
module tb_opp_rx_parser;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        btnc = 1'b1;
    logic        axiiv = 1'b0;
    logic [1:0]  axiid = 2'b00;
    logic [10:0] r_opp_x, r_opp_y;
    logic [8:0]  r_opp_dir;
    logic [2:0]  r_opp_game;
    logic        receive_axiov, link_up;
    logic [7:0]  bad_frames;

    opp_rx_parser #(.MAGIC(8'hA5), .TIMEOUT_CYCLES(TMO), .MAX_DIR(359)) dut (
        .clk(clk), .btnc(btnc), .axiiv(axiiv), .axiid(axiid),
        .r_opp_x(r_opp_x), .r_opp_y(r_opp_y), .r_opp_dir(r_opp_dir),
        .r_opp_game(r_opp_game), .receive_axiov(receive_axiov),
        .link_up(link_up), .bad_frames(bad_frames)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int n_bad = 0;

    int exp_x, exp_y, exp_dir, exp_game, exp_badcnt, accept_cyc;
    bit ever;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_x = 300; exp_y = 100; exp_dir = 90; exp_game = 0;
        exp_badcnt = 0; ever = 0; accept_cyc = 0;
    endtask

    task automatic check_all(input string tag, input bit exp_axiov);
        bit exp_link;
        exp_link = ever && ((cyc - accept_cyc) < TMO);
        check({tag, ".x"},    32'(r_opp_x),    32'(exp_x));
        check({tag, ".y"},    32'(r_opp_y),    32'(exp_y));
        check({tag, ".dir"},  32'(r_opp_dir),  32'(exp_dir));
        check({tag, ".game"}, 32'(r_opp_game), 32'(exp_game));
        check({tag, ".axiov"}, 32'(receive_axiov), 32'(exp_axiov));
        check({tag, ".link"}, 32'(link_up),    32'(exp_link));
        check({tag, ".bad"},  32'(bad_frames), 32'(exp_badcnt));
    endtask

    function automatic logic [55:0] build(input logic [10:0] x, input logic [10:0] y,
                                          input logic [8:0] dir, input logic [2:0] game,
                                          input logic [7:0] magic, input bit flip);
        logic [39:0] p;
        logic [55:0] f;
        logic [7:0]  c;
        p = {x, y, dir, game, 6'($urandom)};
        c = magic;
        for (int b = 0; b < 5; b++) c = c ^ p[39 - 8*b -: 8];
        if (flip) c = c ^ 8'h01;
        f = {magic, p, c};
        return f;
    endfunction

    task automatic send_frame(input string tag, input logic [10:0] x, input logic [10:0] y,
                              input logic [8:0] dir, input logic [2:0] game,
                              input logic [7:0] magic, input bit flip, input int len);
        logic [55:0] f;
        bit good;
        f = build(x, y, dir, game, magic, flip);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, ".axiov_low"}, 32'(receive_axiov), 32'd0);
            axiiv = 1'b1;
            axiid = (i < 28) ? f[55 - 2*i -: 2] : 2'($urandom);
        end
        @(negedge clk);
        axiiv = 1'b0;
        @(negedge clk);
        good = (len == 28) && (magic == 8'hA5) && !flip && (dir <= 359) && (game <= 2);
        if (good) begin
            exp_x = x; exp_y = y; exp_dir = dir; exp_game = game;
            ever = 1; accept_cyc = cyc;
        end else if (exp_badcnt < 255) begin
            exp_badcnt++;
        end
        check_all(tag, good);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [55:0] f;
        int kind, len;
        logic [10:0] rx, ry;
        logic [8:0]  rd;
        logic [2:0]  rg;
        logic [7:0]  rm;
        bit          rf;

        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset", 1'b0);
        btnc = 1'b0;
        idle(2);

        send_frame("good1", 11'd512, 11'd77, 9'd180, 3'd1, 8'hA5, 0, 28);
        send_frame("chkflip", 11'd5, 11'd6, 9'd7, 3'd0, 8'hA5, 1, 28);
        send_frame("good_after", 11'd1000, 11'd2047, 9'd359, 3'd2, 8'hA5, 0, 28);
        send_frame("len27", 11'd1, 11'd2, 9'd3, 3'd0, 8'hA5, 0, 27);
        send_frame("len30", 11'd1, 11'd2, 9'd3, 3'd0, 8'hA5, 0, 30);
        send_frame("dir360", 11'd9, 11'd9, 9'd360, 3'd0, 8'hA5, 0, 28);
        send_frame("game3", 11'd9, 11'd9, 9'd10, 3'd3, 8'hA5, 0, 28);
        send_frame("magic5a", 11'd9, 11'd9, 9'd10, 3'd0, 8'h5A, 0, 28);

        // reset asserted during dibit 11 while the frame keeps streaming
        f = build(11'd42, 11'd43, 9'd44, 3'd1, 8'hA5, 0);
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = f[55 - 2*i -: 2];
            btnc  = (i == 10);
        end
        model_reset();
        @(negedge clk);
        axiiv = 1'b0;
        @(negedge clk);
        check_all("midreset", 1'b0);
        send_frame("post_reset", 11'd42, 11'd43, 9'd44, 3'd1, 8'hA5, 0, 28);

        idle(TMO - 1);
        check_all("link_before", 1'b0);
        idle(1);
        check_all("link_drop", 1'b0);
        idle(5);
        send_frame("link_restore", 11'd77, 11'd88, 9'd99, 3'd2, 8'hA5, 0, 28);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 8);
            rx = 11'($urandom); ry = 11'($urandom);
            rd = 9'($urandom_range(0, 359)); rg = 3'($urandom_range(0, 2));
            rm = 8'hA5; rf = 0; len = 28;
            case (kind)
                4: rf = 1;
                5: rd = 9'($urandom_range(360, 511));
                6: rg = 3'($urandom_range(3, 7));
                7: len = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 27) : $urandom_range(29, 34);
                8: begin rm = 8'($urandom); if (rm == 8'hA5) rm = 8'h00; end
                default: ;
            endcase
            send_frame("rand", rx, ry, rd, rg, rm, rf, len);
        end

        for (int n = 0; n < 300; n++)
            send_frame("flood", 11'd1, 11'd1, 9'd1, 3'd0, 8'hA5, 0, $urandom_range(1, 4));
        check("sat", 32'(bad_frames), 32'd255);

        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
